// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator bank: FSM state encoding,
// default lane width and saturation limits.
package accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int SAT_W          = 64;

    // Limits are returned wide; callers truncate to their own DATA_W.
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/accum_lane_add.sv
// One lane of the bank update: overwrite, wrapping add or saturating add,
// with a signed-overflow indication that overwrite never raises.
module accum_lane_add
    import accum_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic              overwrite_i,
    input  logic              sat_en_i,
    output logic [DATA_W-1:0] result_o,
    output logic              overflow_o
);

    logic [DATA_W:0] sum_ext;
    logic            sum_ovf;

    // Top bit of the sign-extended sum is the true sign; disagreement with
    // the DATA_W-bit sign means the operands shared a sign the sum lost.
    assign sum_ext = {old_i[DATA_W-1], old_i} + {new_i[DATA_W-1], new_i};
    assign sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];

    always_comb begin
        result_o   = sum_ext[DATA_W-1:0];
        overflow_o = 1'b0;
        if (overwrite_i) begin
            result_o = new_i;
        end else begin
            overflow_o = sum_ovf;
            if (sum_ovf && sat_en_i) begin
                result_o = sum_ext[DATA_W] ? DATA_W'(sat_min(DATA_W))
                                           : DATA_W'(sat_max(DATA_W));
            end
        end
    end

endmodule

// File: rtl/accum_bank.sv
// Multi-entry partial-sum bank between the MAC array and the output buffer:
// one vector update per cycle, drained lane-by-lane over a valid/ready stream.
module accum_bank
    import accum_pkg::*;
#(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int LANE_W   = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ARR_SIZE*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic                       in_overwrite,
    input  logic                       sat_en,
    input  logic                       drain_start,
    input  logic [ADDR_W-1:0]          drain_addr,
    input  logic                       drain_clear,
    output logic                       drain_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [LANE_W-1:0]          out_lane,
    output logic                       out_last,
    output logic [ARR_SIZE-1:0]        ovf_flag,
    input  logic                       ovf_clr
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH][ARR_SIZE];
    logic                clear_q, clear_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [LANE_W-1:0]   out_lane_q, out_lane_d;
    logic                out_last_q, out_last_d;
    logic [ARR_SIZE-1:0] ovf_q, ovf_d;

    logic [DATA_W-1:0]   lane_res [ARR_SIZE];
    logic [ARR_SIZE-1:0] lane_ovf;
    logic [LANE_W-1:0]   lane_nx;
    logic                wr_en, start_ok, hs, hs_last;

    assign wr_en    = (state_q == IDLE) && in_valid && (int'(in_addr) < DEPTH);
    assign start_ok = (state_q == IDLE) && drain_start && (int'(drain_addr) < DEPTH);
    assign hs       = (state_q == DRAIN) && out_valid_q && out_ready;
    assign hs_last  = hs && out_last_q;
    assign lane_nx  = out_lane_q + LANE_W'(1);

    generate
        for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
            accum_lane_add #(.DATA_W(DATA_W)) u_add (
                .old_i       (mem_q[in_addr][gi]),
                .new_i       (in_data[gi*DATA_W +: DATA_W]),
                .overwrite_i (in_overwrite),
                .sat_en_i    (sat_en),
                .result_o    (lane_res[gi]),
                .overflow_o  (lane_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = DRAIN;
            DRAIN:   if (hs_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        drain_busy = (state_q == DRAIN);
    end

    // Lane 0 is forwarded from the adder so a same-cycle write to the drained
    // entry is visible in the first output word.
    always_comb begin
        clear_d     = clear_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;
        if (start_ok) begin
            clear_d     = drain_clear;
            out_valid_d = 1'b1;
            out_addr_d  = drain_addr;
            out_lane_d  = '0;
            out_last_d  = (ARR_SIZE == 1);
            out_data_d  = (wr_en && (in_addr == drain_addr)) ? lane_res[0]
                                                             : mem_q[drain_addr][0];
        end else if (hs_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (hs) begin
            out_lane_d  = lane_nx;
            out_last_d  = (lane_nx == LANE_W'(ARR_SIZE - 1));
            out_data_d  = mem_q[out_addr_q][lane_nx];
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | (wr_en ? lane_ovf : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            clear_q     <= clear_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int l = 0; l < ARR_SIZE; l++) begin
                    mem_q[e][l] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int l = 0; l < ARR_SIZE; l++) begin
                mem_q[in_addr][l] <= lane_res[l];
            end
        end else if (hs_last && clear_q) begin
            for (int l = 0; l < ARR_SIZE; l++) begin
                mem_q[out_addr_q][l] <= '0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_accum_bank.sv
// Scoreboard bench for accum_bank: directed scenarios plus random traffic
// against an integer-arithmetic model of the bank.
module tb_accum_bank;
    localparam int AS = 4;
    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 4;
    localparam int LW = 2;

    typedef longint vec_t [AS];
    typedef struct {
        int     addr;
        int     lane;
        longint data;
        bit     last;
    } word_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AS*DW-1:0]  in_data = '0;
    logic [AW-1:0]     in_addr = '0;
    logic              in_overwrite = 1'b0;
    logic              sat_en = 1'b0;
    logic              drain_start = 1'b0;
    logic [AW-1:0]     drain_addr = '0;
    logic              drain_clear = 1'b0;
    logic              drain_busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_addr;
    logic [LW-1:0]     out_lane;
    logic              out_last;
    logic [AS-1:0]     ovf_flag;
    logic              ovf_clr = 1'b0;

    accum_bank #(.ARR_SIZE(AS), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_overwrite(in_overwrite), .sat_en(sat_en),
        .drain_start(drain_start), .drain_addr(drain_addr),
        .drain_clear(drain_clear), .drain_busy(drain_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_lane(out_lane), .out_last(out_last),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    word_t        exp_q[$];
    longint       mdl [DP][AS];
    bit [AS-1:0]  mdl_ovf;
    int           vectors = 0;
    int           miscompares = 0;
    int           ready_mode = 3;
    int           tog_cnt = 0;
    vec_t         zv = '{default: 0};

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint lane_model(longint old, longint nw, bit ow, bit sat,
                                          output bit ovf);
        longint s, mx, mn;
        mx  = (64'sd1 <<< (DW - 1)) - 1;
        mn  = -(64'sd1 <<< (DW - 1));
        ovf = 1'b0;
        if (ow) return nw;
        s = old + nw;
        if (s > mx || s < mn) begin
            ovf = 1'b1;
            if (sat) return (s > mx) ? mx : mn;
            s = (s > mx) ? s - (64'sd1 <<< DW) : s + (64'sd1 <<< DW);
        end
        return s;
    endfunction

    function automatic vec_t mk(longint a, longint b, longint c, longint d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int e = 0; e < DP; e++)
            for (int l = 0; l < AS; l++) mdl[e][l] = 0;
        mdl_ovf = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus; the bank accepts commands only when no
    // drained word is still outstanding.
    task automatic issue(bit wr, int addr, vec_t vals, bit ow, bit sat,
                         bit dr, int daddr, bit dclr, bit oclr);
        bit          acc, o;
        bit [AS-1:0] setm;
        longint      tmp;
        acc = (exp_q.size() == 0);
        chk("in_ready", longint'(in_ready), longint'(acc));
        in_valid = wr; in_addr = AW'(addr); in_overwrite = ow; sat_en = sat;
        drain_start = dr; drain_addr = AW'(daddr); drain_clear = dclr; ovf_clr = oclr;
        for (int i = 0; i < AS; i++) begin
            tmp = vals[i];
            in_data[i*DW +: DW] = tmp[DW-1:0];
        end
        setm = '0;
        if (acc && wr) begin
            for (int i = 0; i < AS; i++) begin
                mdl[addr][i] = lane_model(mdl[addr][i], vals[i], ow, sat, o);
                setm[i] = o;
            end
        end
        mdl_ovf = (oclr ? '0 : mdl_ovf) | setm;
        if (acc && dr) begin
            for (int i = 0; i < AS; i++) exp_q.push_back('{daddr, i, mdl[daddr][i], i == AS - 1});
            if (dclr) for (int i = 0; i < AS; i++) mdl[daddr][i] = 0;
        end
        tick();
        in_valid = 1'b0; drain_start = 1'b0; ovf_clr = 1'b0; drain_clear = 1'b0;
        chk("ovf_flag", longint'(ovf_flag), longint'(mdl_ovf));
        if (acc && dr) begin
            chk("first_valid", longint'(out_valid), 1);
            chk("first_lane", longint'(out_lane), 0);
        end
    endtask

    task automatic wr_vec(int addr, vec_t v, bit ow, bit sat);
        issue(1'b1, addr, v, ow, sat, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain(int addr, bit clr);
        issue(1'b0, 0, zv, 1'b0, 1'b0, 1'b1, addr, clr, 1'b0);
    endtask

    task automatic ovfclr();
        issue(1'b0, 0, zv, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        chk("busy_after_drain", longint'(drain_busy), 0);
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (tog_cnt % 3 == 0); tog_cnt++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: checks stall stability and pops the scoreboard on handshakes.
    bit          stalled = 1'b0;
    logic [DW-1:0] h_data;
    logic [LW-1:0] h_lane;
    logic          h_last;
    always @(negedge clk) begin
        word_t w;
        if (out_valid && !out_ready) begin
            if (stalled) begin
                chk("stall_data", longint'(out_data), longint'(h_data));
                chk("stall_lane", longint'(out_lane), longint'(h_lane));
                chk("stall_last", longint'(out_last), longint'(h_last));
            end
            stalled = 1'b1;
            h_data = out_data; h_lane = out_lane; h_last = out_last;
        end else begin
            stalled = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("out_data", longint'($signed(out_data)), w.data);
                chk("out_lane", longint'(out_lane), w.lane);
                chk("out_addr", longint'(out_addr), w.addr);
                chk("out_last", longint'(out_last), longint'(w.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        reset = 1'b1;
        tick();
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_busy", longint'(drain_busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_addr", longint'(out_addr), 0);
        chk("rst_out_lane", longint'(out_lane), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_ovf", longint'(ovf_flag), 0);
        tick();
        reset = 1'b0;
        tick();

        // Overwrite then add, drained at full rate
        ready_mode = 0;
        wr_vec(3, mk(1, 2, 3, 4), 1'b1, 1'b0);
        wr_vec(3, mk(10, 20, 30, 40), 1'b0, 1'b0);
        drain(3, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("full_rate_done", exp_q.size(), 0);
        chk("full_rate_idle", longint'(drain_busy), 0);

        // Saturating and wrapping overflow on lane 0
        wr_vec(5, mk('h7FFFFFF0, 0, 0, 0), 1'b1, 1'b0);
        wr_vec(5, mk('h20, 0, 0, 0), 1'b0, 1'b1);
        drain(5, 1'b0);
        wait_drain();
        ovfclr();
        wr_vec(5, mk('h7FFFFFF0, 0, 0, 0), 1'b1, 1'b0);
        wr_vec(5, mk('h20, 0, 0, 0), 1'b0, 1'b0);
        drain(5, 1'b0);
        wait_drain();
        ovfclr();

        // Stalled drain; a write during the drain must be refused
        wr_vec(4, mk(100, -200, 300, -400), 1'b1, 1'b0);
        ready_mode = 1;
        drain(4, 1'b0);
        wr_vec(4, mk(1, 1, 1, 1), 1'b0, 1'b0);
        drain(3, 1'b0);
        wait_drain();
        drain(4, 1'b0);
        wait_drain();

        // Same-cycle write and drain of the same entry
        ready_mode = 0;
        wr_vec(7, mk(1, 1, 1, 1), 1'b1, 1'b0);
        issue(1'b1, 7, mk(5, 5, 5, 5), 1'b0, 1'b0, 1'b1, 7, 1'b0, 1'b0);
        wait_drain();

        // Clear-on-drain, then re-drain and check a neighbour
        wr_vec(2, mk(-7, 8, -9, 10), 1'b1, 1'b0);
        ready_mode = 2;
        drain(2, 1'b1);
        wait_drain();
        drain(2, 1'b0);
        wait_drain();
        drain(3, 1'b0);
        wait_drain();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            for (int i = 0; i < AS; i++)
                v[i] = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 200)) - 100
                                                   : longint'(int'($urandom));
            issue(1'($urandom_range(0, 1)), $urandom_range(0, DP - 1), v,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, DP - 1),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end
        wait_drain();

        // Reset while lane 1 is on the output
        ready_mode = 0;
        wr_vec(3, mk(9, 9, 9, 9), 1'b1, 1'b0);
        drain(3, 1'b0);
        tick();
        chk("pre_reset_lane", longint'(out_lane), 1);
        ready_mode = 3;
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_busy", longint'(drain_busy), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_ovf", longint'(ovf_flag), 0);
        model_reset();
        reset = 1'b0;
        tick();
        ready_mode = 0;
        drain(3, 1'b0);
        wait_drain();
        drain(7, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
- Parametrised successor to the single-entry accumulator between the MAC array and the output buffer.
- Holds DEPTH entries; each entry is ARR_SIZE lanes of signed DATA_W partial sums.
- Accepts one MAC result vector per cycle and adds it into, or overwrites, the addressed entry, with optional saturation.
- On command, drains one entry lane-by-lane to the output buffer over a valid/ready stream, optionally clearing the entry after it is read.

Parameters:
ARR_SIZE, 4, number of lanes (MAC columns)
DATA_W, 32, lane width, signed two's complement
DEPTH, 16, entries in the bank
ADDR_W, $clog2(DEPTH), entry address width
LANE_W, $clog2(ARR_SIZE) (min 1), lane index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  MAC vector valid
in_ready  out  1  bank can accept a vector
in_data  in  ARR_SIZE*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_addr  in  ADDR_W  target entry
in_overwrite  in  1  1 = write in_data; 0 = add to entry
sat_en  in  1  1 = saturating add; 0 = wrapping add
drain_start  in  1  start draining entry drain_addr (pulse)
drain_addr  in  ADDR_W  entry to drain
drain_clear  in  1  zero the entry after its last lane is accepted
drain_busy  out  1  drain in progress
out_valid  out  1  output word valid
out_ready  in  1  output buffer accepts word
out_data  out  DATA_W  lane value
out_addr  out  ADDR_W  entry being drained
out_lane  out  LANE_W  lane index of out_data
out_last  out  1  final lane of the entry
ovf_flag  out  ARR_SIZE  sticky per-lane overflow
ovf_clr  in  1  clear ovf_flag

Behaviour:
- Single clock clk; reset synchronous, active-high.
- Reset values:
  - all storage 0; FSM = IDLE
  - in_ready=1, drain_busy=0, out_valid=0, out_data=0, out_addr=0, out_lane=0, out_last=0, ovf_flag=0
- Reset asserted mid-drain aborts the drain with no further output words.
- FSM has two states: IDLE and DRAIN.
- IDLE:
  - in_ready=1.
  - in_valid accepted: addressed entry updated at the clock edge, so latency is 1 cycle.
  - drain_start latches drain_addr and drain_clear, sets lane counter to 0, and moves to DRAIN.
  - in_valid and drain_start in the same cycle: the vector is committed first. The drain then reads the updated value, even when addresses match.
- DRAIN:
  - in_ready=0; drain_busy=1; drain_start ignored.
  - Output register loads lane 0 on the first DRAIN cycle, so out_valid rises 1 cycle after drain_start.
  - out_data, out_lane, out_addr and out_last are stable while out_valid && !out_ready.
  - On each out_valid && out_ready handshake, the next lane loads in the same edge, giving 1 word/cycle under continuous ready.
  - On the handshake with out_last=1 (lane ARR_SIZE-1):
    - out_valid drops and the FSM returns to IDLE.
    - If the latched drain_clear is 1, all lanes of the entry are zeroed.
  - in_ready returns to 1 the cycle after that handshake.
- Arithmetic, per lane:
  - Full signed add with a DATA_W+1-bit intermediate.
  - Overflow: both operands share a sign and the sum sign differs.
  - sat_en=1: overflowed result clamps to +2^(DATA_W-1)-1 or -2^(DATA_W-1).
  - sat_en=0: overflowed result wraps.
  - Either mode sets the lane's ovf_flag bit.
  - in_overwrite=1 never sets ovf_flag.
- ovf_flag:
  - Sticky until ovf_clr or reset.
  - ovf_clr and a new overflow in the same cycle: the flag stays set.
- Addresses: in_addr and drain_addr ≥ DEPTH (non-power-of-2 DEPTH) are ignored. Writes are dropped and drain_start is ignored.

Decomposition:
- Package accum_pkg holds:
  - state enum {IDLE, DRAIN}
  - DATA_W-parametric functions sat_max and sat_min
  - localparam for the default lane width
- One sub-module, accum_lane_add:
  - Combinational.
  - Inputs: old value, new value, overwrite, sat_en.
  - Outputs: result, overflow.
  - Instantiated ARR_SIZE times.
- Storage and FSM stay in accum_bank.

Test Plan:
1. Reset, then write entry 3 with lanes {1,2,3,4} (overwrite), add {10,20,30,40}, then drain_start addr 3 with out_ready=1.
   - Outputs 11,22,33,44 on 4 consecutive cycles, lanes 0..3.
   - out_last only on lane 3; first out_valid 1 cycle after drain_start.
2. Lane 0 = 0x7FFFFFF0, add 0x20.
   - sat_en=1: result 0x7FFFFFFF.
   - sat_en=0: result 0x80000010.
   - In both cases ovf_flag=4'b0001, cleared by ovf_clr.
3. Drain with out_ready toggling 1,0,0,1,…
   - No word is lost or duplicated; data is held stable while stalled.
   - in_valid during DRAIN sees in_ready=0 and does not change storage.
4. In the same cycle, in_valid adds {5,5,5,5} to entry 7 (previously {1,1,1,1}) and drain_start targets addr 7.
   - Drained values are 6,6,6,6.
5. drain_clear=1 drain of entry 2, then a second drain of entry 2.
   - Second drain outputs all zeros; other entries are unchanged.
6. Assert reset during lane 1 of a drain.
   - Next cycle: out_valid=0, drain_busy=0, in_ready=1, all entries 0.
